// File: rtl/bundle_seq.sv
// Bundles cfg_num binary hypervectors into one majority-vote vector using a
// bank of D per-dimension counters sequenced by a CLR/ACC/THR/OUT controller.

module bundle_seq_lane #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic          bit_i,
    input  logic          thr_i,
    input  logic [CW-1:0] num_i,
    output logic          hv_o
);
    logic [CW-1:0] cnt_q;
    logic          hv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            hv_q  <= 1'b0;
        end else begin
            if (clr_i)
                cnt_q <= '0;
            else if (inc_i)
                cnt_q <= cnt_q + {{(CW-1){1'b0}}, bit_i};
            // 2*cnt > num in CW+2 bits; ties fall to 0
            if (thr_i)
                hv_q <= ({1'b0, cnt_q, 1'b0} > {2'b00, num_i});
        end
    end

    assign hv_o = hv_q;
endmodule

module bundle_seq #(
    parameter int D  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] cfg_num,
    input  logic          abort,
    output logic          busy,
    input  logic          hv_valid,
    output logic          hv_ready,
    input  logic [D-1:0]  hv_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [D-1:0]  out_hv
);
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_ACC, S_THR, S_OUT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] num_q, num_d;
    logic [CW-1:0] rcv_q, rcv_d;
    logic          hv_ready_q, out_valid_q;
    logic          beat, clr, inc, thr;
    logic [D-1:0]  hv_q;

    assign beat = hv_valid & hv_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            rcv_q       <= '0;
            hv_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            rcv_q       <= rcv_d;
            // Handshake flags are registered off the next state
            hv_ready_q  <= (state_d == S_ACC);
            out_valid_q <= (state_d == S_OUT);
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        rcv_d   = rcv_q;
        case (state_q)
            S_IDLE: if (start && cfg_num != '0) begin
                num_d   = cfg_num;
                state_d = S_CLR;
            end
            S_CLR: begin
                rcv_d   = '0;
                state_d = S_ACC;
            end
            S_ACC: if (beat) begin
                rcv_d = rcv_q + 1'b1;
                if (rcv_q == num_q - 1'b1)
                    state_d = S_THR;
            end
            S_THR: state_d = S_OUT;
            S_OUT: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE)
            state_d = S_IDLE;
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        clr  = (state_q == S_CLR);
        inc  = beat && !abort;
        thr  = (state_q == S_THR);
    end

    for (genvar i = 0; i < D; i++) begin : g_lane
        bundle_seq_lane #(.CW(CW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr_i (clr),
            .inc_i (inc),
            .bit_i (hv_data[i]),
            .thr_i (thr),
            .num_i (num_q),
            .hv_o  (hv_q[i])
        );
    end

    assign hv_ready  = hv_ready_q;
    assign out_valid = out_valid_q;
    assign out_hv    = hv_q;
endmodule
